path_delay_sequencer: RTL
=========================

// Module: path_delay_sequencer
// PURPOSE
// - Sequences delay measurements on NUM_PATHS single-path delay chains under test.
// - Selects one path, holds its input stable, launches a transition and counts clk cycles until
//   the synchronised path output follows. Repeats 2**SAMPLES_LOG2 times with alternating polarity.
// - Reports the accumulated count for trojan-detection comparison against a golden sum.
// - Sits between the host/UART control logic and the path input/output muxes.
// PARAMETERS
// NUM_PATHS     4     number of selectable paths; PSEL_W = $clog2(NUM_PATHS), minimum 1
// CNT_W         12    per-sample cycle counter width
// SAMPLES_LOG2  3     log2 of the number of samples per measurement
// SETTLE_CYC    16    cycles the launch level is held before each launch (>=1)
// TIMEOUT       4095  per-sample cycle limit (<= 2**CNT_W-1)
// PATH_INV      0     1 = path output is expected to equal ~launch
// PORTS
// clk           in   1                  system clock
// rst           in   1                  synchronous, active-high reset
// start         in   1                  request a measurement; sampled only in IDLE
// path_sel_in   in   PSEL_W             path to measure; latched when start is accepted
// busy          out  1                  high from start acceptance until the result handshake
// path_sel_out  out  PSEL_W             drives the path mux; stable while busy
// launch        out  1                  registered drive to the selected path input
// path_out      in   1                  raw (asynchronous) path output; two-flop synchronised inside
// res_valid     out  1                  result available
// res_ready     in   1                  result consumed
// res_sum       out  CNT_W+SAMPLES_LOG2 sum of all sample counts
// res_path      out  PSEL_W             path the result belongs to
// res_timeout   out  1                  at least one sample hit TIMEOUT
// res_min       out  CNT_W              (PATH_MINMAX_EN only) smallest sample count
// res_max       out  CNT_W              (PATH_MINMAX_EN only) largest sample count
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; counters, sum and sync flops cleared.
// - Reset mid-operation aborts the measurement at once: no result is produced and launch goes to 0.
// - States:
//   - IDLE: start=1 and res_valid=0 -> latch the path, clear sum/idx/flags, busy=1, go to SETTLE.
//   - SETTLE: hold launch for SETTLE_CYC cycles, then go to LAUNCH.
//   - LAUNCH: one cycle; launch <= ~launch, cnt <= 0, go to WAIT.
//   - WAIT: cnt increments each cycle. Exit to RECORD when sync_out == (launch ^ PATH_INV),
//     or when cnt == TIMEOUT (sets the timeout flag).
//   - RECORD: sum += cnt; idx++. If idx wraps at 2**SAMPLES_LOG2, go to DONE, else to SETTLE.
//   - DONE: res_* registered and res_valid=1, held stable until res_ready=1.
//     After the handshake: res_valid=0, busy=0, go to IDLE.
// - Sample count = path delay in cycles + 2 synchroniser cycles. Successive samples alternate
//   rising and falling launches.
// - res_sum width is exact; no saturation or overflow is possible.
// - start while busy is ignored. start in the same cycle as the DONE handshake is ignored; the
//   requester re-asserts it.
// - res_ready outside DONE has no effect.
// - path_sel_out never changes while busy=1, so no mux glitch during a measurement.
// CONFIGURATION
// - PATH_MINMAX_EN defined: res_min/res_max ports exist. min is initialised to all ones and max to 0
//   at start acceptance; both are updated in RECORD. A timed-out sample records TIMEOUT.
// - Undefined: the ports, registers and compare logic are absent; all other behaviour is identical.
// TESTING
// - Model path delay 5 cycles, path_sel_in=2 -> res_sum=56 (8x7), res_path=2, res_timeout=0,
//   path_sel_out=2 for the whole busy window.
// - Path output stuck at 0 -> every sample hits TIMEOUT; res_sum=32760, res_timeout=1.
// - Delays alternating 3/6 with PATH_MINMAX_EN -> res_min=5, res_max=8, res_sum=52.
// - Hold res_ready=0 for 10 cycles in DONE while pulsing start -> res_* stable, no new measurement.
//   Then res_ready=1 -> IDLE next cycle.
// - rst=1 for 1 cycle during WAIT -> next cycle all outputs 0, state IDLE.
//   A subsequent start gives a correct res_sum=56.
// - PATH_INV=1 with an inverting 4-cycle path -> res_sum=48.

Source files
------------

// File: rtl/path_delay_sequencer.sv
// Measures one selectable delay path by repeated alternating-polarity launches and cycle counting.
// Define PATH_MINMAX_EN to also report the smallest and largest sample count per measurement.
module path_delay_sequencer #(
  parameter int NUM_PATHS    = 4,
  parameter int CNT_W        = 12,
  parameter int SAMPLES_LOG2 = 3,
  parameter int SETTLE_CYC   = 16,
  parameter int TIMEOUT      = 4095,
  parameter bit PATH_INV     = 1'b0,
  localparam int PSEL_W      = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1,
  localparam int SUM_W       = CNT_W + SAMPLES_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PSEL_W-1:0] path_sel_in,
  output logic              busy,
  output logic [PSEL_W-1:0] path_sel_out,
  output logic              launch,
  input  logic              path_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_sum,
  output logic [PSEL_W-1:0] res_path,
  output logic              res_timeout
`ifdef PATH_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  res_min,
  output logic [CNT_W-1:0]  res_max
`endif
);

  localparam int IDX_W = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'((1 << SAMPLES_LOG2) - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_RECORD, S_DONE
  } state_t;

  state_t            state_q;
  logic              syncMeta_q, syncOut_q;
  logic              launch_q, busy_q, armed_q, timedOut_q;
  logic [PSEL_W-1:0] pathSel_q;
  logic [SET_W-1:0]  settle_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              resValid_q, resTimeout_q;
  logic [SUM_W-1:0]  resSum_q;
  logic [PSEL_W-1:0] resPath_q;
  logic              target, arrived;
`ifdef PATH_MINMAX_EN
  logic [CNT_W-1:0]  min_q, max_q, min_d, max_d, resMin_q, resMax_q;

  assign min_d   = (cnt_q < min_q) ? cnt_q : min_q;
  assign max_d   = (cnt_q > max_q) ? cnt_q : max_q;
  assign res_min = resMin_q;
  assign res_max = resMax_q;
`endif

  assign sum_d  = sum_q + SUM_W'(cnt_q);
  assign target = launch_q ^ PATH_INV;
  // The path must first be seen at its pre-launch level, so a stuck output times out instead of
  // matching instantly on every other sample.
  assign arrived = armed_q && (syncOut_q == target);

  assign busy         = busy_q;
  assign path_sel_out = pathSel_q;
  assign launch       = launch_q;
  assign res_valid    = resValid_q;
  assign res_sum      = resSum_q;
  assign res_path     = resPath_q;
  assign res_timeout  = resTimeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      syncMeta_q   <= 1'b0;
      syncOut_q    <= 1'b0;
      launch_q     <= 1'b0;
      busy_q       <= 1'b0;
      armed_q      <= 1'b0;
      timedOut_q   <= 1'b0;
      pathSel_q    <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      resValid_q   <= 1'b0;
      resTimeout_q <= 1'b0;
      resSum_q     <= '0;
      resPath_q    <= '0;
`ifdef PATH_MINMAX_EN
      min_q        <= '0;
      max_q        <= '0;
      resMin_q     <= '0;
      resMax_q     <= '0;
`endif
    end else begin
      syncMeta_q <= path_out;
      syncOut_q  <= syncMeta_q;
      case (state_q)
        S_IDLE: begin
          if (start && !resValid_q) begin
            pathSel_q  <= path_sel_in;
            sum_q      <= '0;
            idx_q      <= '0;
            timedOut_q <= 1'b0;
            settle_q   <= '0;
            busy_q     <= 1'b1;
`ifdef PATH_MINMAX_EN
            min_q      <= '1;
            max_q      <= '0;
`endif
            state_q    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= S_LAUNCH;
          else settle_q <= settle_q + SET_W'(1);
        end
        S_LAUNCH: begin
          launch_q <= ~launch_q;
          cnt_q    <= '0;
          armed_q  <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (arrived) begin
            state_q <= S_RECORD;
          end else if (cnt_q == TIMEOUT_C) begin
            timedOut_q <= 1'b1;
            state_q    <= S_RECORD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (syncOut_q != target) armed_q <= 1'b1;
          end
        end
        S_RECORD: begin
          sum_q    <= sum_d;
          idx_q    <= idx_q + IDX_W'(1);
          settle_q <= '0;
`ifdef PATH_MINMAX_EN
          min_q    <= min_d;
          max_q    <= max_d;
`endif
          if (idx_q == LAST_IDX) begin
            resValid_q   <= 1'b1;
            resSum_q     <= sum_d;
            resPath_q    <= pathSel_q;
            resTimeout_q <= timedOut_q;
`ifdef PATH_MINMAX_EN
            resMin_q     <= min_d;
            resMax_q     <= max_d;
`endif
            state_q      <= S_DONE;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
